// File: rtl/wb_write_port_pkg.sv
// Shared constants and types for the register-file write port.
// WORD_LEN / REG_FILE_ADDR_LEN / REG_FILE_SIZE mirror the core-wide defines;
// WB_DEPTH_DEFAULT is the default write-buffer depth.
package wb_write_port_pkg;

    localparam int WORD_LEN          = 32;
    localparam int REG_FILE_ADDR_LEN = 5;
    localparam int REG_FILE_SIZE     = 32;
    localparam int WB_DEPTH_DEFAULT  = 4;

    // One queued register-file write
    typedef struct packed {
        logic [REG_FILE_ADDR_LEN-1:0] dest;
        logic [WORD_LEN-1:0]          data;
    } wb_req_t;

    // Register 0 is hardwired; writes to it are dropped at the door
    function automatic logic dest_live(input logic [REG_FILE_ADDR_LEN-1:0] d);
        return d != '0;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order write buffer: storage, head/tail pointers and occupancy count.
// When WB_BYPASS_EN is defined it also searches all held entries (including
// the one currently on the write port) for the youngest match per read port.
module wb_fifo
    import wb_write_port_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [REG_FILE_ADDR_LEN-1:0] push_dest,
    input  logic [WORD_LEN-1:0]          push_data,
    input  logic                         pop,
    output logic [CNT_W-1:0]             count,
    output logic [REG_FILE_ADDR_LEN-1:0] head_dest,
    output logic [WORD_LEN-1:0]          head_data,
    output logic [REG_FILE_ADDR_LEN-1:0] next_dest,
    output logic [WORD_LEN-1:0]          next_data
`ifdef WB_BYPASS_EN
    ,
    input  logic [REG_FILE_ADDR_LEN-1:0] rd_addr1,
    input  logic [REG_FILE_ADDR_LEN-1:0] rd_addr2,
    output logic                         byp_hit1,
    output logic                         byp_hit2,
    output logic [WORD_LEN-1:0]          byp_data1,
    output logic [WORD_LEN-1:0]          byp_data2
`endif
);

    wb_req_t          mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;

    // Entry storage is data-only, so it carries no reset
    always_ff @(posedge clk) begin
        if (push) mem[tail_ptr] <= '{dest: push_dest, data: push_data};
    end

    // Pointers wrap naturally at PTR_W bits; count tracks net push/pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + PTR_W'(1);
            if (pop)  head_ptr <= head_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Head and the entry behind it, so the write port can advance every cycle
    always_comb begin
        head_dest = mem[head_ptr].dest;
        head_data = mem[head_ptr].data;
        next_dest = mem[head_ptr + PTR_W'(1)].dest;
        next_data = mem[head_ptr + PTR_W'(1)].data;
    end

`ifdef WB_BYPASS_EN
    // Walk oldest to youngest so the last match found is the youngest
    always_comb begin
        byp_hit1  = 1'b0;
        byp_hit2  = 1'b0;
        byp_data1 = '0;
        byp_data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count) begin
                if (rd_addr1 != '0 && mem[head_ptr + PTR_W'(i)].dest == rd_addr1) begin
                    byp_hit1  = 1'b1;
                    byp_data1 = mem[head_ptr + PTR_W'(i)].data;
                end
                if (rd_addr2 != '0 && mem[head_ptr + PTR_W'(i)].dest == rd_addr2) begin
                    byp_hit2  = 1'b1;
                    byp_data2 = mem[head_ptr + PTR_W'(i)].data;
                end
            end
        end
    end
`endif

endmodule

// File: rtl/wb_write_port.sv
// Register-file write master. Arbitrates MEM (priority) over EX into an
// in-order buffer, drops writes to register 0, and drives one registered
// write per cycle. Optional decode bypass view under WB_BYPASS_EN.
module wb_write_port
    import wb_write_port_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ex_valid,
    output logic                         ex_ready,
    input  logic [REG_FILE_ADDR_LEN-1:0] ex_dest,
    input  logic [WORD_LEN-1:0]          ex_data,
    input  logic                         mem_valid,
    output logic                         mem_ready,
    input  logic [REG_FILE_ADDR_LEN-1:0] mem_dest,
    input  logic [WORD_LEN-1:0]          mem_data,
    output logic                         wr_en,
    output logic [REG_FILE_ADDR_LEN-1:0] wr_reg,
    output logic [WORD_LEN-1:0]          wr_data,
    output logic [$clog2(DEPTH):0]       pending
`ifdef WB_BYPASS_EN
    ,
    input  logic [REG_FILE_ADDR_LEN-1:0] rd_addr1,
    input  logic [REG_FILE_ADDR_LEN-1:0] rd_addr2,
    output logic                         byp_hit1,
    output logic                         byp_hit2,
    output logic [WORD_LEN-1:0]          byp_data1,
    output logic [WORD_LEN-1:0]          byp_data2
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0]             count;
    logic                         not_full;
    logic                         mem_fire;
    logic                         ex_fire;
    logic                         push;
    logic [REG_FILE_ADDR_LEN-1:0] push_dest;
    logic [WORD_LEN-1:0]          push_data;
    logic [REG_FILE_ADDR_LEN-1:0] head_dest;
    logic [WORD_LEN-1:0]          head_data;
    logic [REG_FILE_ADDR_LEN-1:0] next_dest;
    logic [WORD_LEN-1:0]          next_data;

    // Ready depends only on registered count, so a same-cycle drain never
    // reopens a full buffer. Dest-0 results still handshake, then vanish.
    always_comb begin
        not_full  = count < CNT_W'(DEPTH);
        mem_ready = not_full;
        ex_ready  = not_full && !mem_valid;
        mem_fire  = mem_valid && mem_ready;
        ex_fire   = ex_valid && ex_ready;
        push_dest = mem_fire ? mem_dest : ex_dest;
        push_data = mem_fire ? mem_data : ex_data;
        push      = (mem_fire || ex_fire) && dest_live(push_dest);
        pending   = count;
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_dest (push_dest),
        .push_data (push_data),
        .pop       (wr_en),
        .count     (count),
        .head_dest (head_dest),
        .head_data (head_data),
        .next_dest (next_dest),
        .next_data (next_data)
`ifdef WB_BYPASS_EN
        ,
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .byp_hit1  (byp_hit1),
        .byp_hit2  (byp_hit2),
        .byp_data1 (byp_data1),
        .byp_data2 (byp_data2)
`endif
    );

    // The head stays counted while on the port and pops at the next edge;
    // if more entries wait behind it, the one after the head goes out next.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en   <= 1'b0;
            wr_reg  <= '0;
            wr_data <= '0;
        end else if (wr_en) begin
            wr_en <= count > CNT_W'(1);
            if (count > CNT_W'(1)) begin
                wr_reg  <= next_dest;
                wr_data <= next_data;
            end
        end else begin
            wr_en <= count != '0;
            if (count != '0) begin
                wr_reg  <= head_dest;
                wr_data <= head_data;
            end
        end
    end

endmodule

// File: doc/wb_write_port.md
# wb_write_port

Write-side master for the CPU register file: accepts completed results from the execute stage (ALU) and the memory stage (loads) over valid/ready handshakes and queues them in a small in-order buffer. It then drives the register file's single write port with at most one write per cycle. It sits between the EX/MEM result buses and the register file. It optionally gives the decode stage a bypass view of writes that are queued but not yet committed.

## Interface
Parameters:
- DEPTH, 4, number of write-buffer entries (power of two, ≥2)

Ports:
- clk  input  1  system clock; all state updates on posedge
- reset  input  1  asynchronous, active-low reset
- ex_valid  input  1  ALU result offered
- ex_ready  output  1  ALU result accepted this cycle when high with ex_valid
- ex_dest  input  REG_FILE_ADDR_LEN  ALU destination register
- ex_data  input  WORD_LEN  ALU result
- mem_valid  input  1  load result offered
- mem_ready  output  1  load result accepted this cycle when high with mem_valid
- mem_dest  input  REG_FILE_ADDR_LEN  load destination register
- mem_data  input  WORD_LEN  load data
- wr_en  output  1  register-file write enable (registered)
- wr_reg  output  REG_FILE_ADDR_LEN  register-file write address (registered)
- wr_data  output  WORD_LEN  register-file write data (registered)
- pending  output  log2(DEPTH)+1  entries held, including the one on the write port
- rd_addr1, rd_addr2  input  REG_FILE_ADDR_LEN  decode read addresses (WB_BYPASS_EN only)
- byp_hit1, byp_hit2  output  1  pending write to that address exists (WB_BYPASS_EN only)
- byp_data1, byp_data2  output  WORD_LEN  youngest pending data for that address (WB_BYPASS_EN only)

## Operation
- Arbitration: one enqueue per cycle at most. MEM has fixed priority over EX.
  - mem_ready = (count < DEPTH).
  - ex_ready = (count < DEPTH) && !mem_valid.
- A handshake with dest == 0 is accepted (ready behaves normally) and then discarded. It is never enqueued and never written.
- Buffer is strictly FIFO. Write order equals acceptance order.
- Drain: while the buffer is non-empty, the head is presented on wr_en/wr_reg/wr_data for exactly one cycle and then popped. Throughput is one write per cycle.
- count is updated as +1 on enqueue and −1 on drain. Simultaneous enqueue and drain leave count unchanged.
- pending = count.
- Head/tail pointers are log2(DEPTH) bits and wrap modulo DEPTH.

## Timing
- Reset (asynchronous, reset low): count=0, pointers=0, wr_en=0, wr_reg=0, wr_data=0, pending=0. Both ready outputs read 1 immediately (count 0).
- Latency: a result accepted at posedge N into an empty buffer appears with wr_en=1 after posedge N+1.
- The register file samples on negedge, so the write commits mid-cycle N+1.
- Full: when count==DEPTH, both ready outputs are low. A drain in the same cycle does not reopen ready; there is no full-cycle pass-through. Ready rises the cycle after count drops.
- Simultaneous ex_valid and mem_valid: MEM is taken and EX stalls. EX is taken on the next cycle in which mem_valid is low.
- Reset asserted mid-operation: all queued writes are dropped, and wr_en falls asynchronously.
- Inputs are sampled only on a handshake. Data and dest may change freely while ready is low.

## Configuration
- WB_BYPASS_EN defined: compare rd_addrN against every valid entry, including the one currently on the write port.
  - byp_hitN = 1 if any entry matches and rd_addrN != 0.
  - byp_dataN = data of the youngest matching entry.
  - Both outputs are combinational.
- WB_BYPASS_EN undefined: rd_addr1/2, byp_hit1/2 and byp_data1/2 ports are not present. No comparators are built.

## Structure
- WORD_LEN, REG_FILE_ADDR_LEN and REG_FILE_SIZE come from the shared defines.v.
- Add WB_DEPTH_DEFAULT to defines.v.
- Sub-module wb_fifo: storage, pointers, count, and, under WB_BYPASS_EN, the youngest-match search.
- The top level holds arbitration, the dest==0 filter and the write-port registers.

## Test plan
- After reset, single EX write (dest=5, data=0x1234) → wr_en=1, wr_reg=5, wr_data=0x1234 for exactly one cycle, one cycle after the handshake; pending returns to 0.
- Both valid same cycle (MEM dest=3/0xAA, EX dest=4/0xBB) → ex_ready=0 in that cycle; writes occur in order reg3 then reg4 on consecutive cycles.
- EX valid with dest=0, data=0xFFFF → handshake completes, no wr_en pulse, pending stays 0.
- Hold wr_en draining while offering 5 back-to-back MEM results with DEPTH=4 → ready drops when pending=4, then reappears. All 5 writes emerge in order, with no loss or duplication.
- WB_BYPASS_EN: queue reg7=0x10 then reg7=0x20, with rd_addr1=7 → byp_hit1=1 and byp_data1=0x20. With rd_addr2=0 → byp_hit2=0.
- Pull reset low with 3 entries queued → wr_en=0 and pending=0 immediately. No further writes after reset is released.
